stereo_frame_buffer: RTL and testbench
======================================

Name: stereo_frame_buffer

Overview:
Double-buffered (ping-pong) multi-channel frame store for the SAD disparity pipeline. The camera side writes NUM_CH pixel channels (default 2: left and right) into one bank while the SAD engine reads the previously completed frame from the other bank. Banks swap on explicit end-of-frame and release events. Both ports use the buf_* valid/ready handshake of the single-frame image buffer, generalised in channel count and frame mode.

Parameters:
CAMERA_HSIZE, 100, pixels per line
CAMERA_VSIZE, 100, lines per frame
BUF_ADDR_WIDTH, clog2(CAMERA_HSIZE*CAMERA_VSIZE) (=14), pixel address width
PIXEL_SIZE, 12, bits per pixel per channel
NUM_CH, 2, channels stored per address (1..4)

Ports:
clk  in  1  single clock, all logic on rising edge
rst_n  in  1  synchronous, active-low reset
buf_waddr  in  BUF_ADDR_WIDTH  write pixel address
buf_wdata  in  NUM_CH*PIXEL_SIZE  write pixels; channel k at bits [k*PIXEL_SIZE +: PIXEL_SIZE]
buf_wvalid  in  1  write request
buf_wlast  in  1  qualifies the current write beat as the last of a frame
buf_wready  out  1  write bank available
buf_raddr  in  BUF_ADDR_WIDTH  read pixel address
buf_rvalid  in  1  read request
buf_rready  out  1  completed frame available for reading
buf_rdata  out  NUM_CH*PIXEL_SIZE  read pixels, same channel packing as buf_wdata
buf_rdvalid  out  1  buf_rdata valid this cycle
rd_release  in  1  pulse: reader is finished with the current read bank
frame_avail  out  1  at least one complete frame is stored
addr_err  out  1  sticky out-of-range address flag

Behaviour:
- State: wr_bank (1 bit), rd_bank (1 bit), full_cnt (0..2).
- Reset (rst_n=0 at clk edge): wr_bank=0, rd_bank=0, full_cnt=0, buf_rdata=0, buf_rdvalid=0, addr_err=0. buf_wready=1 and buf_rready=0 after reset. Memory contents are not reset. Reset mid-frame discards the partial frame and any stored frames.
- buf_wready = (full_cnt<2). buf_rready = frame_avail = (full_cnt>0). Both are combinational from registered state only and never depend on valid inputs.
- Write handshake (buf_wvalid & buf_wready): write buf_wdata to bank wr_bank at buf_waddr, all channels in the same cycle. A write with buf_wvalid=1 and buf_wready=0 is ignored; the source holds it.
- Write beat with buf_wlast=1 accepted: wr_bank toggles, full_cnt+1. A frame may have any number of beats ≥1; unwritten addresses keep stale data.
- Read handshake (buf_rvalid & buf_rready): read bank rd_bank at buf_raddr. Latency 1: next cycle buf_rdvalid=1 and buf_rdata=pixels. Otherwise buf_rdvalid=0 and buf_rdata holds its last value. Back-to-back reads at 1 per cycle.
- rd_release with full_cnt>0: rd_bank toggles, full_cnt−1. With full_cnt=0: ignored. A read accepted in the same cycle as the release uses the old rd_bank.
- Simultaneous wlast accept and valid release: both toggles apply, and full_cnt is unchanged.
- Write and read of the same address in the same cycle always target different banks, so there is no hazard.
- Address ≥ CAMERA_HSIZE*CAMERA_VSIZE: a write is accepted but dropped (wlast still counts); a read is accepted and returns 0 with buf_rdvalid=1. Both set addr_err=1, which stays set until reset.

Test Plan:
- HSIZE=4, VSIZE=3, NUM_CH=2. After reset, check buf_wready=1, buf_rready=0, frame_avail=0, buf_rdvalid=0. Send buf_rvalid=1 → no buf_rdvalid.
- Write addresses 0..11 with data {ch1=addr+0x100, ch0=addr}, wlast on 11 → frame_avail=1. Read address 5 → one cycle later buf_rdata={0x105,0x005}, buf_rdvalid=1.
- Write two frames with no release → buf_wready=0 after the second wlast. The next write is held. Pulse rd_release → buf_wready=1 next cycle. Reads now return frame-2 data.
- Frame 3 written with ch0=0xAAA while reading frame 2 back-to-back on addresses 0..11 → every read returns frame-2 data with no 0xAAA value, 12 consecutive rdvalid cycles.
- full_cnt=1: assert wlast accept and rd_release in the same cycle → frame_avail stays 1, buf_wready stays 1, and both bank pointers toggle.
- Write to address 13 → addr_err=1, no memory change. Read address 13 → buf_rdata=0. Assert rst_n=0 mid-frame → addr_err=0, frame_avail=0, buf_wready=1.

Source files
------------

// File: rtl/stereo_frame_buffer.sv
// Ping-pong multi-channel frame store: the camera fills one bank while the SAD
// engine reads the last completed frame from the other; banks swap on wlast/release.
module stereo_frame_buffer #(
  parameter int CAMERA_HSIZE   = 100,
  parameter int CAMERA_VSIZE   = 100,
  parameter int BUF_ADDR_WIDTH = $clog2(CAMERA_HSIZE * CAMERA_VSIZE),
  parameter int PIXEL_SIZE     = 12,
  parameter int NUM_CH         = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [BUF_ADDR_WIDTH-1:0]      buf_waddr,
  input  logic [NUM_CH*PIXEL_SIZE-1:0]   buf_wdata,
  input  logic                           buf_wvalid,
  input  logic                           buf_wlast,
  output logic                           buf_wready,
  input  logic [BUF_ADDR_WIDTH-1:0]      buf_raddr,
  input  logic                           buf_rvalid,
  output logic                           buf_rready,
  output logic [NUM_CH*PIXEL_SIZE-1:0]   buf_rdata,
  output logic                           buf_rdvalid,
  input  logic                           rd_release,
  output logic                           frame_avail,
  output logic                           addr_err
);

  localparam int DEPTH = CAMERA_HSIZE * CAMERA_VSIZE;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int DW    = NUM_CH * PIXEL_SIZE;
  localparam logic [BUF_ADDR_WIDTH:0] DEPTH_W = (BUF_ADDR_WIDTH + 1)'(DEPTH);

  function automatic logic addr_in_range(input logic [BUF_ADDR_WIDTH-1:0] a);
    return {1'b0, a} < DEPTH_W;
  endfunction

  logic [DW-1:0] mem_q [2][DEPTH];

  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [1:0]    full_cnt_q, full_cnt_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rdvalid_q, rdvalid_d;
  logic          addr_err_q, addr_err_d;

  logic wr_fire, rd_fire, wlast_fire, rel_fire, waddr_ok, raddr_ok;

  // Ready flags depend only on the stored-frame count, never on the valids.
  assign buf_wready  = (full_cnt_q < 2'd2);
  assign buf_rready  = (full_cnt_q != 2'd0);
  assign frame_avail = buf_rready;
  assign buf_rdata   = rdata_q;
  assign buf_rdvalid = rdvalid_q;
  assign addr_err    = addr_err_q;

  assign wr_fire    = buf_wvalid & buf_wready;
  assign rd_fire    = buf_rvalid & buf_rready;
  assign wlast_fire = wr_fire & buf_wlast;
  assign rel_fire   = rd_release & (full_cnt_q != 2'd0);
  assign waddr_ok   = addr_in_range(buf_waddr);
  assign raddr_ok   = addr_in_range(buf_raddr);

  always_comb begin
    wr_bank_d  = wr_bank_q ^ wlast_fire;
    rd_bank_d  = rd_bank_q ^ rel_fire;
    full_cnt_d = full_cnt_q + {1'b0, wlast_fire} - {1'b0, rel_fire};
    rdvalid_d  = rd_fire;
    rdata_d    = rdata_q;
    addr_err_d = addr_err_q | (wr_fire & ~waddr_ok) | (rd_fire & ~raddr_ok);
    // Reads use the bank selected before any same-cycle release takes effect.
    if (rd_fire) begin
      rdata_d = '0;
      if (raddr_ok) rdata_d = mem_q[rd_bank_q][buf_raddr[IDX_W-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      full_cnt_q <= 2'd0;
      rdata_q    <= '0;
      rdvalid_q  <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      full_cnt_q <= full_cnt_d;
      rdata_q    <= rdata_d;
      rdvalid_q  <= rdvalid_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Pixel storage is not reset; the write bank never equals an active read bank.
  always_ff @(posedge clk) begin
    if (wr_fire && waddr_ok) mem_q[wr_bank_q][buf_waddr[IDX_W-1:0]] <= buf_wdata;
  end

endmodule

// File: tb/tb_stereo_frame_buffer.sv
// Directed bench for stereo_frame_buffer on a 4x3, two-channel configuration.
module tb_stereo_frame_buffer;

  localparam int H  = 4;
  localparam int V  = 3;
  localparam int AW = 4;
  localparam int PS = 12;
  localparam int NC = 2;
  localparam int W  = NC * PS;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] buf_waddr;
  logic [W-1:0]  buf_wdata;
  logic          buf_wvalid;
  logic          buf_wlast;
  logic          buf_wready;
  logic [AW-1:0] buf_raddr;
  logic          buf_rvalid;
  logic          buf_rready;
  logic [W-1:0]  buf_rdata;
  logic          buf_rdvalid;
  logic          rd_release;
  logic          frame_avail;
  logic          addr_err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  stereo_frame_buffer #(
    .CAMERA_HSIZE(H), .CAMERA_VSIZE(V), .BUF_ADDR_WIDTH(AW),
    .PIXEL_SIZE(PS), .NUM_CH(NC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .buf_waddr(buf_waddr), .buf_wdata(buf_wdata), .buf_wvalid(buf_wvalid),
    .buf_wlast(buf_wlast), .buf_wready(buf_wready),
    .buf_raddr(buf_raddr), .buf_rvalid(buf_rvalid), .buf_rready(buf_rready),
    .buf_rdata(buf_rdata), .buf_rdvalid(buf_rdvalid),
    .rd_release(rd_release), .frame_avail(frame_avail), .addr_err(addr_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    buf_wvalid = 1'b0;
    buf_wlast  = 1'b0;
    buf_rvalid = 1'b0;
    rd_release = 1'b0;
  endtask

  task automatic wr(input int a, input logic [W-1:0] d, input logic last);
    buf_wvalid = 1'b1;
    buf_waddr  = AW'(a);
    buf_wdata  = d;
    buf_wlast  = last;
    tick();
    idle();
  endtask

  task automatic rd(input int a);
    buf_rvalid = 1'b1;
    buf_raddr  = AW'(a);
    tick();
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    buf_waddr = '0;
    buf_wdata = '0;
    buf_raddr = '0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;

    chk("rst_wready", buf_wready, 1);
    chk("rst_rready", buf_rready, 0);
    chk("rst_avail", frame_avail, 0);
    chk("rst_rdvalid", buf_rdvalid, 0);
    chk("rst_rdata", buf_rdata, 0);
    chk("rst_addr_err", addr_err, 0);

    rd(0);
    chk("empty_read_rdvalid", buf_rdvalid, 0);

    // Frame 1 into bank 0: {ch1=0x100+a, ch0=a}
    for (int i = 0; i < 12; i++) wr(i, {12'h100 + 12'(i), 12'(i)}, i == 11);
    chk("f1_avail", frame_avail, 1);
    chk("f1_wready", buf_wready, 1);

    rd(5);
    chk("f1_rd5_rdvalid", buf_rdvalid, 1);
    chk("f1_rd5_rdata", buf_rdata, 24'h105005);
    tick();
    chk("rdvalid_drop", buf_rdvalid, 0);
    chk("rdata_hold", buf_rdata, 24'h105005);

    // Frame 2 into bank 1: {ch1=0x200+a, ch0=0x020+a}
    for (int i = 0; i < 12; i++) wr(i, {12'h200 + 12'(i), 12'h020 + 12'(i)}, i == 11);
    chk("full_wready", buf_wready, 0);
    chk("full_avail", frame_avail, 1);

    buf_wvalid = 1'b1;
    buf_waddr  = 4'd0;
    buf_wdata  = 24'hFFFFFF;
    buf_wlast  = 1'b1;
    tick();
    chk("held_wready_1", buf_wready, 0);
    tick();
    chk("held_wready_2", buf_wready, 0);
    idle();

    rd(0);
    chk("held_not_written", buf_rdata, 24'h100000);

    rd_release = 1'b1;
    tick();
    idle();
    chk("rel_wready", buf_wready, 1);
    chk("rel_avail", frame_avail, 1);

    rd(7);
    chk("f2_rd7", buf_rdata, 24'h207027);

    // Frame 3 (bank 0, ch0=0xAAA) written while frame 2 is streamed out
    for (int i = 0; i < 12; i++) begin
      buf_wvalid = 1'b1;
      buf_waddr  = AW'(i);
      buf_wdata  = {12'h300 + 12'(i), 12'hAAA};
      buf_wlast  = (i == 11);
      buf_rvalid = 1'b1;
      buf_raddr  = AW'(i);
      tick();
      chk($sformatf("stream_rdvalid_%0d", i), buf_rdvalid, 1);
      chk($sformatf("stream_rdata_%0d", i), buf_rdata, {12'h200 + 12'(i), 12'h020 + 12'(i)});
    end
    idle();
    chk("f3_wready", buf_wready, 0);

    rd_release = 1'b1;
    tick();
    idle();

    // full_cnt=1: single-beat frame 4 with release and a read in the same cycle
    buf_wvalid = 1'b1;
    buf_waddr  = 4'd0;
    buf_wdata  = 24'h400444;
    buf_wlast  = 1'b1;
    rd_release = 1'b1;
    buf_rvalid = 1'b1;
    buf_raddr  = 4'd1;
    tick();
    idle();
    chk("sim_avail", frame_avail, 1);
    chk("sim_wready", buf_wready, 1);
    chk("sim_read_old_bank", buf_rdata, 24'h301AAA);

    rd(0);
    chk("sim_rdbank_toggled", buf_rdata, 24'h400444);
    rd(2);
    chk("sim_bank1_stale", buf_rdata, 24'h202022);

    wr(3, 24'h555555, 1'b1);
    chk("f5_wready", buf_wready, 0);
    rd_release = 1'b1;
    tick();
    idle();
    rd(3);
    chk("sim_wrbank_toggled", buf_rdata, 24'h555555);

    chk("pre_addr_err", addr_err, 0);
    wr(13, 24'hEEEEEE, 1'b0);
    chk("oor_wr_addr_err", addr_err, 1);
    chk("oor_wr_wready", buf_wready, 1);
    wr(12, 24'hDDDDDD, 1'b1);
    chk("oor_wlast_counts", buf_wready, 0);

    rd(13);
    chk("oor_rd_rdvalid", buf_rdvalid, 1);
    chk("oor_rd_rdata", buf_rdata, 0);
    tick();
    chk("addr_err_sticky", addr_err, 1);

    rd(3);
    chk("oor_no_mem_change", buf_rdata, 24'h555555);

    // Reset in the middle of a frame
    buf_wvalid = 1'b1;
    buf_waddr  = 4'd1;
    buf_wdata  = 24'h123456;
    rst_n      = 1'b0;
    tick();
    idle();
    rst_n = 1'b1;
    chk("mid_rst_addr_err", addr_err, 0);
    chk("mid_rst_avail", frame_avail, 0);
    chk("mid_rst_wready", buf_wready, 1);
    chk("mid_rst_rdata", buf_rdata, 0);
    rd(3);
    chk("mid_rst_no_read", buf_rdvalid, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
